// File: rtl/svfloat_ftoi_seq_pkg.sv
// rtl/svfloat_ftoi_seq_pkg.sv - shared svfloat types for the float-to-integer converter
package svfloat_ftoi_seq_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

endpackage

// File: rtl/svfloat_unpacker.sv
// rtl/svfloat_unpacker.sv - splits a float into class flags, true exponent and mantissa
// Subnormals come out with the minimum normal exponent and a zero hidden bit.
module svfloat_unpacker #(
  parameter int exp_width = 8,
  parameter int man_width = 23
) (
  input  logic                        sign_i,
  input  logic [exp_width-1:0]        exp_i,
  input  logic [man_width-1:0]        man_i,
  output logic                        sign_o,
  output logic signed [exp_width+1:0] e_o,
  output logic [man_width:0]          m_o,
  output logic                        nan_o,
  output logic                        inf_o,
  output logic                        zero_o
);

  localparam logic signed [exp_width+1:0] bias  = (exp_width+2)'((1 << (exp_width-1)) - 1);
  localparam logic signed [exp_width+1:0] e_min = (exp_width+2)'(2 - (1 << (exp_width-1)));

  logic exp_max;
  logic exp_zero;
  logic man_nz;

  always_comb begin
    exp_max  = &exp_i;
    exp_zero = ~|exp_i;
    man_nz   = |man_i;
    sign_o   = sign_i;
    nan_o    = exp_max & man_nz;
    inf_o    = exp_max & ~man_nz;
    zero_o   = exp_zero & ~man_nz;
    m_o      = {~exp_zero, man_i};
    e_o      = exp_zero ? e_min : ($signed({2'b00, exp_i}) - bias);
  end

endmodule

// File: rtl/svfloat_ftoi_seq.sv
// rtl/svfloat_ftoi_seq.sv - multi-cycle float-to-integer converter, round toward zero
// One bit of alignment shift per cycle; specials and n=0 resolve at capture.
module svfloat_ftoi_seq
  import svfloat_ftoi_seq_pkg::*;
#(
  parameter type float     = float32,
  parameter int  int_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [$bits(float)-1:0] in_val,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [int_width-1:0]  out_int,
  output logic                  out_invalid,
  output logic                  out_inexact
);

  float in_f;
  assign in_f = in_val;

  localparam int man_width = $bits(in_f.man);
  localparam int exp_width = $bits(in_f.exp);
  localparam int acc_w     = (int_width > man_width + 1) ? int_width : man_width + 1;
  localparam int cnt_w     = $clog2(acc_w + 1);

  localparam logic [int_width-1:0] smax_w   = {1'b0, {(int_width-1){1'b1}}};
  localparam logic [int_width-1:0] smin_w   = {1'b1, {(int_width-1){1'b0}}};
  localparam logic [acc_w-1:0]     smag_max = {{(acc_w-int_width+1){1'b0}}, {(int_width-1){1'b1}}};
  localparam logic [acc_w-1:0]     smin_mag = smag_max + acc_w'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q;
  logic                 sign_q, signed_q, left_q, sticky_q;
  logic [acc_w-1:0]     acc_q;
  logic [cnt_w-1:0]     cnt_q;
  logic [int_width-1:0] int_q;
  logic                 invalid_q, inexact_q;

  logic                        u_sign, u_nan, u_inf, u_zero;
  logic signed [exp_width+1:0] u_e;
  logic [man_width:0]          u_m;

  svfloat_unpacker #(.exp_width(exp_width), .man_width(man_width)) u_unpack (
    .sign_i(in_f.sign), .exp_i(in_f.exp), .man_i(in_f.man),
    .sign_o(u_sign), .e_o(u_e), .m_o(u_m),
    .nan_o(u_nan), .inf_o(u_inf), .zero_o(u_zero)
  );

  int                   e_int, cap_n;
  logic                 cap_left;
  logic [acc_w-1:0]     acc_d;
  logic                 sticky_d;
  logic [acc_w-1:0]     fin_mag;
  logic                 fin_sticky, fin_sign, fin_signed;
  logic [int_width-1:0] fin_int, sat_int;
  logic                 fin_inv, fin_inx;

  always_comb begin
    e_int    = int'(u_e);
    cap_left = e_int > man_width;
    cap_n    = cap_left ? (e_int - man_width) : (man_width - e_int);
    sat_int  = in_signed ? (u_sign ? smin_w : smax_w) : (u_sign ? '0 : '1);

    acc_d    = left_q ? (acc_q << 1) : (acc_q >> 1);
    sticky_d = sticky_q | (~left_q & acc_q[0]);

    // The final step either finishes a shift or, for n=0, uses the captured mantissa directly.
    if (state_q == IDLE) begin
      fin_mag    = acc_w'(u_m);
      fin_sticky = 1'b0;
      fin_sign   = u_sign;
      fin_signed = in_signed;
    end else begin
      fin_mag    = acc_d;
      fin_sticky = sticky_d;
      fin_sign   = sign_q;
      fin_signed = signed_q;
    end

    fin_int = '0;
    fin_inv = 1'b0;
    fin_inx = fin_sticky;
    if (fin_signed) begin
      if (!fin_sign) begin
        if (fin_mag > smag_max) begin
          fin_int = smax_w; fin_inv = 1'b1; fin_inx = 1'b0;
        end else begin
          fin_int = fin_mag[int_width-1:0];
        end
      end else if (fin_mag > smin_mag) begin
        fin_int = smin_w; fin_inv = 1'b1; fin_inx = 1'b0;
      end else begin
        fin_int = -fin_mag[int_width-1:0];
      end
    end else if (fin_sign) begin
      if (fin_mag != '0) begin
        fin_inv = 1'b1; fin_inx = 1'b0;
      end else begin
        fin_inx = 1'b1;
      end
    end else begin
      fin_int = fin_mag[int_width-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      signed_q  <= 1'b0;
      left_q    <= 1'b0;
      sticky_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      int_q     <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q   <= u_sign;
          signed_q <= in_signed;
          sticky_q <= 1'b0;
          if (u_nan) begin
            int_q <= in_signed ? smax_w : '1; invalid_q <= 1'b1; inexact_q <= 1'b0;
            state_q <= DONE;
          end else if (u_inf || e_int >= int_width) begin
            int_q <= sat_int; invalid_q <= 1'b1; inexact_q <= 1'b0;
            state_q <= DONE;
          end else if (u_zero) begin
            int_q <= '0; invalid_q <= 1'b0; inexact_q <= 1'b0;
            state_q <= DONE;
          end else if (e_int < 0) begin
            int_q <= '0; invalid_q <= 1'b0; inexact_q <= 1'b1;
            state_q <= DONE;
          end else if (cap_n == 0) begin
            int_q <= fin_int; invalid_q <= fin_inv; inexact_q <= fin_inx;
            state_q <= DONE;
          end else begin
            acc_q   <= acc_w'(u_m);
            cnt_q   <= cnt_w'(cap_n);
            left_q  <= cap_left;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q    <= acc_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q - cnt_w'(1);
          if (cnt_q == cnt_w'(1)) begin
            int_q <= fin_int; invalid_q <= fin_inv; inexact_q <= fin_inx;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_int     = int_q;
  assign out_invalid = invalid_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_svfloat_ftoi_seq.sv
// tb/tb_svfloat_ftoi_seq.sv - directed self-checking bench for svfloat_ftoi_seq
module tb_svfloat_ftoi_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_val = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_int;
  logic        out_invalid;
  logic        out_inexact;

  int passed = 0;
  int total  = 0;
  int lat;
  bit seen;

  always #5 clk = ~clk;

  svfloat_ftoi_seq #(.int_width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Returns edges from the accepting edge (counted as 1) until out_valid is seen.
  task automatic run(input logic [31:0] v, input logic s, output int l);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    in_val = v; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_val = 32'hDEADBEEF; in_signed = ~s;
    l = 1;
    while (!out_valid && l < 200) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic conv(input string tag, input logic [31:0] v, input logic s,
                      input logic [31:0] exp_int, input logic exp_inv, input logic exp_inx,
                      input int exp_lat);
    int l;
    run(v, s, l);
    chk({tag, ".lat"}, 32'(l), 32'(exp_lat));
    chk({tag, ".int"}, out_int, exp_int);
    chk({tag, ".inv"}, {31'd0, out_invalid}, {31'd0, exp_inv});
    chk({tag, ".inx"}, {31'd0, out_inexact}, {31'd0, exp_inx});
    pop();
    chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst.in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst.out_valid", {31'd0, out_valid},   32'd0);
    chk("rst.out_int",   out_int,              32'd0);
    chk("rst.invalid",   {31'd0, out_invalid}, 32'd0);
    chk("rst.inexact",   {31'd0, out_inexact}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    conv("p3_75",    32'h40700000, 1'b1, 32'h00000003, 1'b0, 1'b1, 23);
    conv("neg2p31",  32'hCF000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 9);
    conv("2p31_s",   32'h4F000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 9);
    conv("2p31_u",   32'h4F000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 9);
    conv("nan_s",    32'h7FC00000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
    conv("ninf_u",   32'hFF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1);
    conv("2p32_u",   32'h4F800000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    conv("n0_5_u",   32'hBF000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1);
    conv("n1_0_u",   32'hBF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 24);
    conv("subn",     32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 1);
    conv("nzero_u",  32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
    conv("n1_5_s",   32'hBFC00000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 24);
    conv("p1e7_s",   32'h4B189680, 1'b1, 32'h00989680, 1'b0, 1'b0, 1);

    // Backpressure: 100.0 held while out_ready stays low.
    run(32'h42C80000, 1'b1, lat);
    chk("bp.lat", 32'(lat), 32'd18);
    for (int i = 0; i < 5; i++) begin
      chk("bp.int",   out_int,              32'd100);
      chk("bp.valid", {31'd0, out_valid},   32'd1);
      chk("bp.ready", {31'd0, in_ready},    32'd0);
      chk("bp.flags", {30'd0, out_invalid, out_inexact}, 32'd0);
      @(posedge clk); #1;
    end
    pop();
    chk("bp.release", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a shift sequence.
    in_val = 32'h40700000; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar.in_ready",  {31'd0, in_ready},  32'd1);
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("ar.no_result", {31'd0, seen}, 32'd0);
    conv("ar.p3_0", 32'h40400000, 1'b1, 32'h00000003, 1'b0, 1'b0, 23);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/svfloat_ftoi_seq.md
Name: svfloat_ftoi_seq

Overview:
Multi-cycle float-to-integer converter. It is the reverse direction of the adder/packer datapath: it takes a packed svfloat value and produces a W-bit signed or unsigned integer, rounding toward zero, with RISC-V style saturation and flags. It uses a one-bit-per-cycle shifter behind valid/ready handshakes, for area-constrained FPU front ends.

Parameters:
float, svfloat::float32, floating-point type (sign/exponent/mantissa struct).
int_width, 32, output integer width W (≥2).

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operand valid
in_ready  out  1  converter can accept an operand
in_val  in  $bits(float)  packed float operand
in_signed  in  1  1 = signed result, 0 = unsigned; sampled with operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_int  out  int_width  converted integer
out_invalid  out  1  NaN, infinity or out-of-range (saturated)
out_inexact  out  1  nonzero fraction bits discarded (only when out_invalid=0)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset forces state IDLE, out_valid=0, out_int=0, out_invalid=0, out_inexact=0, in_ready=1. Reset mid-operation aborts the conversion silently.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid, latch sign, in_signed, true exponent e and normalized mantissa m (man_width+1 bits) from svfloat_unpacker. The value equals m·2^(e−man_width).
- Special cases are resolved at capture and go directly to DONE:
  - NaN: signed gives 2^(W−1)−1; unsigned gives all-ones. invalid=1.
  - Infinity, or e ≥ W: saturate (signed: max/min by sign; unsigned: all-ones if positive, 0 if negative). invalid=1.
  - Zero (either sign): 0, no flags.
  - e < 0 (includes subnormals): 0, inexact=1, no invalid, even if negative unsigned.
- Otherwise go to SHIFT with count n=|e−man_width| and direction left if e>man_width, else right. Accumulator width is max(W, man_width+1).
- SHIFT: one bit per cycle; decrement n. On right shifts, OR each dropped bit into sticky. When n reaches 0 (or n=0 at capture), go to DONE and compute the result from magnitude M:
  - signed, positive: M > 2^(W−1)−1 gives max, invalid.
  - signed, negative: M > 2^(W−1) gives min, invalid; else out_int = −M.
  - unsigned, negative: M ≠ 0 gives 0, invalid; M = 0 gives 0, inexact.
  - unsigned, positive: out_int = M (fits because e ≤ W−1).
  - inexact = sticky when not invalid.
- Latency: out_valid rises n+1 edges after the accepting edge (n=0 for specials). Maximum n is max(man_width, W−1−man_width).
- DONE: out_int and flags are held stable while out_valid && !out_ready. On out_ready go to IDLE; the next operand can be accepted on the following edge, giving no overlap and no bubble-free back-to-back.
- in_val and in_signed are don't-care outside the accepting cycle.

Decomposition:
- No new package types. The state enum (2-bit) stays local.
- Reuse the existing svfloat_unpacker for exponent/mantissa/class extraction; no new sub-module.
- Saturation constants are derived locally from int_width.

Test Plan:
- 3.75 (0x40700000), signed, W=32 → out_int=3, inexact=1, invalid=0; out_valid 23 edges after accept (n=22).
- −2^31 (0xCF000000) signed → 0x80000000, no flags. 2^31 (0x4F000000) signed → 0x7FFFFFFF invalid. 2^31 unsigned → 0x80000000, no flags.
- NaN 0x7FC00000 signed → 0x7FFFFFFF invalid; −inf 0xFF800000 unsigned → 0 invalid; both have out_valid 1 edge after accept.
- −0.5 (0xBF000000) unsigned → 0, inexact=1, invalid=0. −1.0 (0xBF800000) unsigned → 0, invalid=1. Subnormal 0x00000001 → 0, inexact=1.
- Backpressure: 100.0 (0x42C80000) signed with out_ready low 5 cycles → out_int=100 held stable, in_ready=0 throughout; accept after release.
- Reset: assert rst_n=0 in the middle of SHIFT → out_valid=0 and in_ready=1 immediately (async); no result emitted after release; the next conversion is correct.
